// File: rtl/rename_map_unit_pkg.sv
// Shared widths and types for the rename stage at its default configuration.
`timescale 1ns/1ps
package rename_pkg;
  localparam int NUM_ARCH_DEF = 32;
  localparam int NUM_PHYS_DEF = 64;
  localparam int CTRL_W_DEF   = 88;
  localparam int AW           = $clog2(NUM_ARCH_DEF);
  localparam int PW           = $clog2(NUM_PHYS_DEF);
  localparam int FREE_DEPTH   = NUM_PHYS_DEF - NUM_ARCH_DEF;
  localparam int CW           = $clog2(FREE_DEPTH + 1);

  typedef logic [AW-1:0] arch_t;
  typedef logic [PW-1:0] phys_t;

  typedef struct packed {
    logic [31:0]           pc;
    logic [31:0]           instr;
    logic [CTRL_W_DEF-1:0] ctrl;
    phys_t                 ps;
    phys_t                 pt;
    phys_t                 pd;
    phys_t                 old_pd;
    logic                  ps_busy;
    logic                  pt_busy;
  } rn_out_t;
endpackage

// File: rtl/rename_map_unit_free_list.sv
// Circular free list of physical registers with a speculative head, a commit
// head and a tail; restore rewinds the speculative head to committed state.
`timescale 1ns/1ps
module rename_free_list #(
  parameter int  NUM_ARCH = 32,
  parameter int  NUM_PHYS = 64,
  localparam int DEPTH    = NUM_PHYS - NUM_ARCH,
  localparam int PHYS_W   = $clog2(NUM_PHYS),
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              pop,
  input  logic              push,
  input  logic [PHYS_W-1:0] push_pd,
  input  logic              commit_adv,
  input  logic              restore,
  output logic [PHYS_W-1:0] pop_pd,
  output logic [CNT_W-1:0]  count
);

  logic [PHYS_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  spec_head, commit_head, tail;
  logic [IDX_W-1:0]  tail_n, commit_head_n;
  logic [CNT_W-1:0]  restore_cnt;

  function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  assign pop_pd = mem[spec_head];

  // Committed occupancy after this cycle's push; equal pointers mean full,
  // since the committed free set always holds every unmapped register.
  always_comb begin
    tail_n        = push ? inc(tail) : tail;
    commit_head_n = commit_adv ? inc(commit_head) : commit_head;
    if (tail_n == commit_head_n)
      restore_cnt = CNT_W'(DEPTH);
    else if (tail_n > commit_head_n)
      restore_cnt = CNT_W'(tail_n - commit_head_n);
    else
      restore_cnt = CNT_W'(DEPTH) - CNT_W'(commit_head_n - tail_n);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= PHYS_W'(NUM_ARCH + i);
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= '0;
      count       <= CNT_W'(DEPTH);
    end else begin
      if (push) begin
        mem[tail] <= push_pd;
        tail      <= inc(tail);
      end
      if (commit_adv) commit_head <= inc(commit_head);
      if (restore) begin
        spec_head <= commit_head_n;
        count     <= restore_cnt;
      end else begin
        if (pop) spec_head <= inc(spec_head);
        case ({pop, push})
          2'b10:   count <= count - CNT_W'(1);
          2'b01:   count <= count + CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  assert property (@(posedge CLK) disable iff (RESET)
    !(push && !pop && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/rename_map_unit.sv
// Register rename stage: speculative and committed maps, busy table, free list
// and a one-deep output register with valid/ready handshakes on both sides.
`timescale 1ns/1ps
module rename_map_unit
  import rename_pkg::*;
#(
  parameter int  NUM_ARCH = NUM_ARCH_DEF,
  parameter int  NUM_PHYS = NUM_PHYS_DEF,
  parameter int  CTRL_W   = CTRL_W_DEF,
  localparam int ARCH_W   = $clog2(NUM_ARCH),
  localparam int PHYS_W   = $clog2(NUM_PHYS),
  localparam int CNT_W    = $clog2(NUM_PHYS - NUM_ARCH + 1)
)(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [ARCH_W-1:0] in_rs,
  input  logic [ARCH_W-1:0] in_rt,
  input  logic [ARCH_W-1:0] in_rd,
  input  logic              in_wr,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [PHYS_W-1:0] out_ps,
  output logic [PHYS_W-1:0] out_pt,
  output logic [PHYS_W-1:0] out_pd,
  output logic [PHYS_W-1:0] out_old_pd,
  output logic              out_ps_busy,
  output logic              out_pt_busy,
  input  logic              wb_valid,
  input  logic [PHYS_W-1:0] wb_pd,
  input  logic              cm_valid,
  input  logic [ARCH_W-1:0] cm_rd,
  input  logic [PHYS_W-1:0] cm_pd,
  input  logic [PHYS_W-1:0] cm_old_pd,
  output logic [CNT_W-1:0]  free_count
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [CTRL_W-1:0] ctrl;
    logic [PHYS_W-1:0] ps;
    logic [PHYS_W-1:0] pt;
    logic [PHYS_W-1:0] pd;
    logic [PHYS_W-1:0] old_pd;
    logic              ps_busy;
    logic              pt_busy;
  } out_t;

  logic [PHYS_W-1:0] frat [NUM_ARCH];
  logic [PHYS_W-1:0] rrat [NUM_ARCH];
  logic [NUM_PHYS-1:0] busy;

  logic              need, fire, pop, cm_wr;
  logic [PHYS_W-1:0] pop_pd, ps_p0, pt_p0, old_p0;
  out_t              rn_p0, rn_p1;
  logic              vld_p1;

  rename_free_list #(
    .NUM_ARCH (NUM_ARCH),
    .NUM_PHYS (NUM_PHYS)
  ) u_free_list (
    .CLK        (CLK),
    .RESET      (RESET),
    .pop        (pop),
    .push       (cm_valid),
    .push_pd    (cm_old_pd),
    .commit_adv (cm_valid),
    .restore    (FLUSH),
    .pop_pd     (pop_pd),
    .count      (free_count)
  );

  assign need     = in_wr && (in_rd != '0);
  assign in_ready = !RESET && !FLUSH && (!vld_p1 || out_ready) &&
                    (!need || free_count != '0);
  assign fire     = in_valid && in_ready;
  assign pop      = fire && need;
  assign cm_wr    = cm_valid && (cm_rd != '0);

  // Stage p0: map lookup before this cycle's remap, busy with writeback bypass
  always_comb begin
    ps_p0         = frat[in_rs];
    pt_p0         = frat[in_rt];
    old_p0        = frat[in_rd];
    rn_p0.pc      = in_pc;
    rn_p0.instr   = in_instr;
    rn_p0.ctrl    = in_ctrl;
    rn_p0.ps      = ps_p0;
    rn_p0.pt      = pt_p0;
    rn_p0.old_pd  = old_p0;
    rn_p0.pd      = need ? pop_pd : old_p0;
    rn_p0.ps_busy = busy[ps_p0] && !(wb_valid && wb_pd == ps_p0);
    rn_p0.pt_busy = busy[pt_p0] && !(wb_valid && wb_pd == pt_p0);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        frat[i] <= PHYS_W'(i);
        rrat[i] <= PHYS_W'(i);
      end
      busy <= '0;
    end else begin
      if (cm_wr) rrat[cm_rd] <= cm_pd;
      if (FLUSH) begin
        for (int i = 0; i < NUM_ARCH; i++) frat[i] <= rrat[i];
        if (cm_wr) frat[cm_rd] <= cm_pd;
        busy <= '0;
      end else begin
        if (pop) frat[in_rd] <= pop_pd;
        if (wb_valid && wb_pd != '0) busy[wb_pd] <= 1'b0;
        if (pop) busy[pop_pd] <= 1'b1;
      end
    end
  end

  // Stage p1: output register, held until the downstream side accepts
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vld_p1 <= 1'b0;
      rn_p1  <= '0;
    end else if (FLUSH) begin
      vld_p1 <= 1'b0;
    end else if (fire) begin
      vld_p1 <= 1'b1;
      rn_p1  <= rn_p0;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_pc      = rn_p1.pc;
  assign out_instr   = rn_p1.instr;
  assign out_ctrl    = rn_p1.ctrl;
  assign out_ps      = rn_p1.ps;
  assign out_pt      = rn_p1.pt;
  assign out_pd      = rn_p1.pd;
  assign out_old_pd  = rn_p1.old_pd;
  assign out_ps_busy = rn_p1.ps_busy;
  assign out_pt_busy = rn_p1.pt_busy;

  assert property (@(posedge CLK) disable iff (RESET)
    !(pop && wb_valid && wb_pd == pop_pd));

endmodule
